// File: rtl/dcache_meta_write_buffer.sv
// Metadata write buffer: FIFO of tag-array updates that drains through the shared
// single tag port, yielding to lookups until the starvation counter forces a write.
module dcache_meta_write_buffer #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int IDX_BITS     = 6,
  parameter int WAYS         = 8,
  parameter int TAG_BITS     = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_enq_valid,
  output logic                io_enq_ready,
  input  logic [IDX_BITS-1:0] io_enq_bits_idx,
  input  logic [WAYS-1:0]     io_enq_bits_way_en,
  input  logic [TAG_BITS-1:0] io_enq_bits_tag,
  input  logic                io_rd_valid,
  input  logic [IDX_BITS-1:0] io_rd_idx,
  output logic                io_rd_ready,
  output logic                io_rd_conflict,
  output logic                io_wr_en,
  output logic [IDX_BITS-1:0] io_wr_idx,
  output logic [WAYS-1:0]     io_wr_way_en,
  output logic [TAG_BITS-1:0] io_wr_tag,
  output logic                io_empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int STALL_W = $clog2(STARVE_LIMIT + 1);

  logic [IDX_BITS-1:0] idx_mem [DEPTH];
  logic [WAYS-1:0]     way_mem [DEPTH];
  logic [TAG_BITS-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0]   head_reg, head_next;
  logic [PTR_W-1:0]   tail_reg, tail_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [STALL_W-1:0] stall_reg, stall_next;

  logic             nonempty;
  logic             starve;
  logic             enq_fire;
  logic             grant;
  logic [DEPTH-1:0] match;

  assign nonempty = (count_reg != '0);
  assign starve   = (stall_reg == STALL_W'(STARVE_LIMIT));

  assign io_enq_ready = (count_reg != CNT_W'(DEPTH)) & ~reset;
  assign enq_fire     = io_enq_valid & io_enq_ready;
  assign grant        = nonempty & (~io_rd_valid | starve) & ~reset;

  assign io_wr_en     = grant;
  assign io_wr_idx    = idx_mem[head_reg];
  assign io_wr_way_en = way_mem[head_reg];
  assign io_wr_tag    = tag_mem[head_reg];
  assign io_rd_ready  = ~(starve & nonempty);
  assign io_empty     = ~nonempty;

  // An entry is live when its distance from head (mod DEPTH) is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] offset;
      assign offset    = PTR_W'(gi) - head_reg;
      assign match[gi] = (CNT_W'(offset) < count_reg) && (idx_mem[gi] == io_rd_idx);
    end
  endgenerate

  assign io_rd_conflict = io_rd_valid & (|match);

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    stall_next = stall_reg;
    if (grant)    head_next = head_reg + PTR_W'(1);
    if (enq_fire) tail_next = tail_reg + PTR_W'(1);
    case ({enq_fire, grant})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
    // Without a grant on a non-empty buffer the head was necessarily blocked.
    if (!nonempty || grant)
      stall_next = '0;
    else if (!starve)
      stall_next = stall_reg + STALL_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      stall_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      stall_reg <= stall_next;
    end
  end

  always_ff @(posedge clock) begin
    if (enq_fire) begin
      idx_mem[tail_reg] <= io_enq_bits_idx;
      way_mem[tail_reg] <= io_enq_bits_way_en;
      tag_mem[tail_reg] <= io_enq_bits_tag;
    end
  end

endmodule

// File: tb/tb_dcache_meta_write_buffer.sv
// Bench for dcache_meta_write_buffer: directed scenarios plus random traffic, all
// checked each cycle against a queue-based model of the buffer.
module tb_dcache_meta_write_buffer;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_enq_valid;
  logic        io_enq_ready;
  logic [5:0]  io_enq_bits_idx;
  logic [7:0]  io_enq_bits_way_en;
  logic [19:0] io_enq_bits_tag;
  logic        io_rd_valid;
  logic [5:0]  io_rd_idx;
  logic        io_rd_ready;
  logic        io_rd_conflict;
  logic        io_wr_en;
  logic [5:0]  io_wr_idx;
  logic [7:0]  io_wr_way_en;
  logic [19:0] io_wr_tag;
  logic        io_empty;

  dcache_meta_write_buffer #(
    .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .IDX_BITS(6), .WAYS(8), .TAG_BITS(20)
  ) dut (
    .clock(clock), .reset(reset),
    .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready),
    .io_enq_bits_idx(io_enq_bits_idx), .io_enq_bits_way_en(io_enq_bits_way_en),
    .io_enq_bits_tag(io_enq_bits_tag),
    .io_rd_valid(io_rd_valid), .io_rd_idx(io_rd_idx), .io_rd_ready(io_rd_ready),
    .io_rd_conflict(io_rd_conflict),
    .io_wr_en(io_wr_en), .io_wr_idx(io_wr_idx), .io_wr_way_en(io_wr_way_en),
    .io_wr_tag(io_wr_tag), .io_empty(io_empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  idx;
    logic [7:0]  way;
    logic [19:0] tag;
  } entry_t;

  entry_t model_q[$];
  int     model_blocked = 0;
  int     checks = 0;
  int     errors = 0;
  int     max_fill = 0;

  logic last_wr_en, last_rd_ready, last_conflict, last_enq_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance it.
  task automatic step(input logic rst, input logic ev, input logic [5:0] ei,
                      input logic [7:0] ew, input logic [19:0] et,
                      input logic rv, input logic [5:0] ri);
    bit   e_enq_ready, e_wr_en, e_rd_ready, e_conflict, e_empty, starving;
    entry_t ent;
    @(negedge clock);
    reset = rst; io_enq_valid = ev; io_enq_bits_idx = ei; io_enq_bits_way_en = ew;
    io_enq_bits_tag = et; io_rd_valid = rv; io_rd_idx = ri;
    #1;
    starving    = (model_blocked >= STARVE_LIMIT);
    e_enq_ready = (model_q.size() < DEPTH) && !rst;
    e_wr_en     = !rst && model_q.size() > 0 && (!rv || starving);
    e_rd_ready  = !(starving && model_q.size() > 0);
    e_empty     = (model_q.size() == 0);
    e_conflict  = 1'b0;
    foreach (model_q[i]) if (rv && model_q[i].idx == ri) e_conflict = 1'b1;
    chk("enq_ready", 32'(io_enq_ready), 32'(e_enq_ready));
    chk("wr_en", 32'(io_wr_en), 32'(e_wr_en));
    chk("rd_ready", 32'(io_rd_ready), 32'(e_rd_ready));
    chk("rd_conflict", 32'(io_rd_conflict), 32'(e_conflict));
    chk("empty", 32'(io_empty), 32'(e_empty));
    if (e_wr_en) begin
      chk("wr_idx", 32'(io_wr_idx), 32'(model_q[0].idx));
      chk("wr_way_en", 32'(io_wr_way_en), 32'(model_q[0].way));
      chk("wr_tag", 32'(io_wr_tag), 32'(model_q[0].tag));
    end
    last_wr_en = io_wr_en; last_rd_ready = io_rd_ready;
    last_conflict = io_rd_conflict; last_enq_ready = io_enq_ready;
    $display("t=%0t rst=%0b enq=%0b/%0b idx=%0h rd=%0b/%0h wr=%0b %0h/%0h/%0h occ=%0d",
             $time, rst, ev, io_enq_ready, ei, rv, ri, io_wr_en, io_wr_idx,
             io_wr_way_en, io_wr_tag, model_q.size());
    @(posedge clock);
    if (rst) begin
      model_q.delete();
      model_blocked = 0;
    end else begin
      if (model_q.size() == 0 || e_wr_en) model_blocked = 0;
      else if (model_blocked < STARVE_LIMIT) model_blocked++;
      if (e_wr_en) void'(model_q.pop_front());
      if (ev && e_enq_ready) begin
        ent.idx = ei; ent.way = ew; ent.tag = et;
        model_q.push_back(ent);
      end
    end
    if (model_q.size() > max_fill) max_fill = model_q.size();
  endtask

  task automatic idle(input logic rv, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 8'd0, 20'd0, rv, 6'd0);
  endtask

  initial begin
    int pre_write_ready;
    reset = 1'b1; io_enq_valid = 1'b0; io_enq_bits_idx = '0; io_enq_bits_way_en = '0;
    io_enq_bits_tag = '0; io_rd_valid = 1'b0; io_rd_idx = '0;
    step(1'b1, 1'b0, 6'd0, 8'd0, 20'd0, 1'b0, 6'd0);
    step(1'b1, 1'b0, 6'd0, 8'd0, 20'd0, 1'b0, 6'd0);
    idle(1'b0, 1);

    // Single write with no lookups.
    step(1'b0, 1'b1, 6'd5, 8'h04, 20'hABCDE, 1'b0, 6'd0);
    idle(1'b0, 1);
    chk("single_wr_en", 32'(last_wr_en), 32'd1);
    idle(1'b0, 1);

    // Fill while lookups hold the port, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 6'(10 + i), 8'(1 << i), 20'(16'h1000 + i), 1'b1, 6'd60);
    step(1'b0, 1'b1, 6'd33, 8'h80, 20'h77777, 1'b1, 6'd60);
    chk("full_enq_ready", 32'(last_enq_ready), 32'd0);
    idle(1'b0, 6);

    // Starvation: one entry with lookups every cycle.
    step(1'b0, 1'b1, 6'd21, 8'h02, 20'h12345, 1'b1, 6'd0);
    pre_write_ready = 0;
    for (int i = 0; i < STARVE_LIMIT + 4; i++) begin
      step(1'b0, 1'b0, 6'd0, 8'd0, 20'd0, 1'b1, 6'd0);
      if (last_wr_en) break;
      if (last_rd_ready) pre_write_ready++;
    end
    chk("starve_ready_cycles", 32'(pre_write_ready), 32'(STARVE_LIMIT));
    chk("starve_forced_wr", 32'(last_wr_en), 32'd1);
    chk("starve_rd_blocked", 32'(last_rd_ready), 32'd0);
    idle(1'b0, 2);

    // Conflict detection.
    step(1'b0, 1'b1, 6'd3, 8'h01, 20'h00003, 1'b1, 6'd50);
    step(1'b0, 1'b1, 6'd9, 8'h02, 20'h00009, 1'b1, 6'd50);
    step(1'b0, 1'b0, 6'd0, 8'd0, 20'd0, 1'b1, 6'd9);
    chk("conflict_hit", 32'(last_conflict), 32'd1);
    step(1'b0, 1'b0, 6'd0, 8'd0, 20'd0, 1'b1, 6'd4);
    chk("conflict_miss", 32'(last_conflict), 32'd0);
    step(1'b0, 1'b1, 6'd7, 8'h04, 20'h00007, 1'b1, 6'd7);
    chk("conflict_same_cycle_enq", 32'(last_conflict), 32'd0);
    idle(1'b0, 5);

    // Wrap-around stream.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 6'(40 + i), 8'(1 << (i % 8)), 20'(20'hA0000 + i), 1'b0, 6'd0);
    idle(1'b0, 3);

    // Reset mid-operation discards buffered entries.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 6'(i + 1), 8'h10, 20'(20'hF0000 + i), 1'b1, 6'd63);
    step(1'b1, 1'b0, 6'd0, 8'd0, 20'd0, 1'b1, 6'd63);
    chk("reset_wr_en", 32'(last_wr_en), 32'd0);
    idle(1'b0, 1);
    chk("post_reset_wr_en", 32'(last_wr_en), 32'd0);
    chk("post_reset_empty", 32'(io_empty), 32'd1);
    idle(1'b0, 3);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6), 6'($urandom_range(0, 15)),
           8'($urandom), 20'($urandom), ($urandom_range(0, 9) < 7), 6'($urandom_range(0, 15)));
    idle(1'b0, 12);
    chk("max_fill_bound", 32'(max_fill <= DEPTH), 32'd1);
    chk("final_empty", 32'(io_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
